// File: rtl/tdm_demux_4ch.sv
// Receive-side TDM demultiplexer: routes a 4-slot serial frame into four
// registered channel outputs, tracking alignment and reporting frames/errors.
module tdm_demux_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic [1:0]       slot
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      slot       <= '0;
      state      <= IDLE;
    end else begin
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (in_valid) begin
        if (frame_start) begin
          // A slot-0 marker always (re)aligns; inside a frame it is an error.
          out0      <= in_data;
          out_valid <= 4'b0001;
          slot      <= 2'd1;
          state     <= RUN;
          if (state == RUN) sync_err <= 1'b1;
        end else if (state == IDLE) begin
          sync_err <= 1'b1;
        end else begin
          case (slot)
            2'd1: begin
              out1      <= in_data;
              out_valid <= 4'b0010;
            end
            2'd2: begin
              out2      <= in_data;
              out_valid <= 4'b0100;
            end
            2'd3: begin
              out3      <= in_data;
              out_valid <= 4'b1000;
            end
            default: begin
              out0      <= in_data;
              out_valid <= 4'b0001;
            end
          endcase
          if (slot == 2'd3) begin
            slot       <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            slot <= slot + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios plus random
// traffic, checked every cycle against a frame-position model.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       frame_start;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic       frame_done;
  logic       sync_err;
  logic [1:0] slot;

  tdm_demux_4ch #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .frame_start(frame_start), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .out_valid(out_valid), .frame_done(frame_done),
    .sync_err(sync_err), .slot(slot)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pos = index of the next sample within the current frame
  // (0 means no frame is open and only a frame_start beat is accepted).
  int         pos = 0;
  logic [7:0] exp_out [4];
  logic [3:0] exp_ov;
  logic       exp_fd, exp_se;
  bit         chk_en = 0;

  int fd_cnt = 0, se_cnt = 0, ov_cnt = 0, cyc_no = 0;
  int fd_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input logic rn, input logic v, input logic fs,
                                     input logic [7:0] d);
    if (!rn) begin
      pos = 0;
      for (int i = 0; i < 4; i++) exp_out[i] = '0;
      exp_ov = '0; exp_fd = 1'b0; exp_se = 1'b0;
      return;
    end
    exp_ov = '0; exp_fd = 1'b0; exp_se = 1'b0;
    if (!v) return;
    if (fs) begin
      exp_se     = (pos != 0);
      exp_out[0] = d;
      exp_ov     = 4'b0001;
      pos        = 1;
    end else if (pos == 0) begin
      exp_se = 1'b1;
    end else begin
      exp_out[pos] = d;
      exp_ov       = 4'(1 << pos);
      if (pos == 3) begin
        exp_fd = 1'b1;
        pos    = 0;
      end else begin
        pos = pos + 1;
      end
    end
  endfunction

  task automatic cyc(input logic rn, input logic v, input logic fs, input logic [7:0] d);
    rst_n = rn; in_valid = v; frame_start = fs; in_data = d;
    @(posedge clk);
    model_step(rn, v, fs, d);
    #1;
  endtask

  task automatic beat(input logic fs, input logic [7:0] d);
    cyc(1'b1, 1'b1, fs, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_no++;
      chk("out0", 32'(out0), 32'(exp_out[0]));
      chk("out1", 32'(out1), 32'(exp_out[1]));
      chk("out2", 32'(out2), 32'(exp_out[2]));
      chk("out3", 32'(out3), 32'(exp_out[3]));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("sync_err", 32'(sync_err), 32'(exp_se));
      chk("slot", 32'(slot), 32'(pos));
      chk("ov_onehot0", 32'($onehot0(out_valid)), 32'd1);
      chk("fd_se_excl", 32'(frame_done & sync_err), 32'd0);
      if (frame_done === 1'b1) begin fd_cnt++; fd_cyc.push_back(cyc_no); end
      if (sync_err === 1'b1) se_cnt++;
      if (out_valid !== 4'b0) ov_cnt++;
    end
  end

  int fd0, se0, ov0, d0, d1;

  initial begin
    // 1. Reset with valid traffic, then one aligned frame
    cyc(1'b0, 1'b1, 1'b1, 8'($urandom));
    chk_en = 1;
    cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("rst_out0", 32'(out0), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);
    beat(1'b1, 8'hA0);
    chk("t1_ov0", 32'(out_valid), 32'h1);
    chk("t1_slot1", 32'(slot), 32'h1);
    beat(1'b0, 8'hB1);
    chk("t1_ov1", 32'(out_valid), 32'h2);
    beat(1'b0, 8'hC2);
    chk("t1_ov2", 32'(out_valid), 32'h4);
    chk("t1_fd_early", 32'(frame_done), 32'h0);
    beat(1'b0, 8'hD3);
    chk("t1_ov3", 32'(out_valid), 32'h8);
    chk("t1_fd", 32'(frame_done), 32'h1);
    chk("t1_outs", {out0, out1, out2, out3}, 32'hA0B1C2D3);
    idle(1);

    // 2. Gapped frame
    fd0 = fd_cnt;
    beat(1'b1, 8'h5A); idle(3);
    chk("t2_slot_hold", 32'(slot), 32'h1);
    beat(1'b0, 8'h6B); idle(3);
    beat(1'b0, 8'h7C); idle(3);
    beat(1'b0, 8'h8D); idle(1);
    chk("t2_outs", {out0, out1, out2, out3}, 32'h5A6B7C8D);
    chk("t2_fd_cnt", 32'(fd_cnt - fd0), 32'd1);

    // 3. Back-to-back frames
    fd0 = fd_cnt;
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33); beat(1'b0, 8'h44);
    beat(1'b1, 8'h55); beat(1'b0, 8'h66); beat(1'b0, 8'h77); beat(1'b0, 8'h88);
    idle(1);
    chk("t3_outs", {out0, out1, out2, out3}, 32'h55667788);
    chk("t3_fd_cnt", 32'(fd_cnt - fd0), 32'd2);
    if (fd_cyc.size() >= 2) begin
      d1 = fd_cyc[fd_cyc.size()-1];
      d0 = fd_cyc[fd_cyc.size()-2];
      chk("t3_fd_gap", 32'(d1 - d0), 32'd4);
    end else begin
      chk("t3_fd_seen", 32'(fd_cyc.size()), 32'd2);
    end

    // 4. Unaligned start
    se0 = se_cnt; ov0 = ov_cnt; fd0 = fd_cnt;
    beat(1'b0, 8'hAA); beat(1'b0, 8'hBB); beat(1'b0, 8'hCC);
    idle(1);
    chk("t4_se_cnt", 32'(se_cnt - se0), 32'd3);
    chk("t4_no_ov", 32'(ov_cnt - ov0), 32'd0);
    beat(1'b1, 8'h01); beat(1'b0, 8'h02); beat(1'b0, 8'h03); beat(1'b0, 8'h04);
    idle(1);
    chk("t4_fd_cnt", 32'(fd_cnt - fd0), 32'd1);
    chk("t4_outs", {out0, out1, out2, out3}, 32'h01020304);

    // 5. Early realign
    se0 = se_cnt; fd0 = fd_cnt;
    beat(1'b1, 8'h10); beat(1'b0, 8'h20);
    beat(1'b1, 8'h30);
    chk("t5_se", 32'(sync_err), 32'h1);
    beat(1'b0, 8'h40); beat(1'b0, 8'h50); beat(1'b0, 8'h60);
    idle(1);
    chk("t5_outs", {out0, out1, out2, out3}, 32'h30405060);
    chk("t5_se_cnt", 32'(se_cnt - se0), 32'd1);
    chk("t5_fd_cnt", 32'(fd_cnt - fd0), 32'd1);

    // 6. Reset mid-frame
    fd0 = fd_cnt;
    beat(1'b1, 8'hE1); beat(1'b0, 8'hE2);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t6_outs", {out0, out1, out2, out3}, 32'h0);
    chk("t6_slot", 32'(slot), 32'h0);
    beat(1'b0, 8'hE3);
    chk("t6_se", 32'(sync_err), 32'h1);
    beat(1'b0, 8'hE4); idle(2);
    chk("t6_no_fd", 32'(fd_cnt - fd0), 32'd0);

    // Random traffic, occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
